// File: rtl/claw_game_sequencer.sv
// Claw machine game sequencer: conditions joystick/button/limit inputs and
// sequences home, play, drop, grip, raise, return and release.
module claw_game_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PLAY_CYCLES     = 1500000000,
    parameter int unsigned DROP_CYCLES     = 200000000,
    parameter int unsigned GRIP_CYCLES     = 100000000,
    parameter int unsigned X_MAX_CYCLES    = 400000000,
    parameter int unsigned Y_MAX_CYCLES    = 400000000,
    parameter int unsigned TIMEOUT_CYCLES  = 800000000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_drop,
    input  logic       limit_x,
    input  logic       limit_y,
    input  logic       limit_z,
    output logic       x_fwd,
    output logic       x_back,
    output logic       y_fwd,
    output logic       y_back,
    output logic       z_down,
    output logic       z_up,
    output logic       grip_close,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_HOME    = 4'd0,
        S_IDLE    = 4'd1,
        S_PLAY    = 4'd2,
        S_DROP    = 4'd3,
        S_GRIP    = 4'd4,
        S_RAISE   = 4'd5,
        S_RETURN  = 4'd6,
        S_RELEASE = 4'd7,
        S_FAULT   = 4'd8
    } state_t;

    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DROP_LAST = 32'(DROP_CYCLES - 1);
    localparam logic [31:0] GRIP_LAST = 32'(GRIP_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] PLAY_LOAD = 32'(PLAY_CYCLES);
    localparam logic [31:0] X_MAX     = 32'(X_MAX_CYCLES);
    localparam logic [31:0] Y_MAX     = 32'(Y_MAX_CYCLES);

    state_t      cur;
    state_t      nxt;

    logic [7:0]  raw;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [4:0]  deb;
    logic        drop_d;
    logic        drop_pulse;

    logic        lim_x;
    logic        lim_y;
    logic        lim_z;
    logic        b_left;
    logic        b_right;
    logic        b_up;
    logic        b_down;

    logic [31:0] xpos;
    logic [31:0] ypos;
    logic [31:0] ptimer;
    logic [31:0] dwell;
    logic        dwell_to;

    logic        xf;
    logic        xb;
    logic        yf;
    logic        yb;
    logic        zd;
    logic        zu;
    logic        gc;
    logic        flt;

    assign raw = {limit_z, limit_y, limit_x,
                  btn_drop, btn_down, btn_up, btn_right, btn_left};

    // Synchronizers carry no reset so limits are valid right after reset.
    always_ff @(posedge CLK100MHZ) begin
        sync1 <= raw;
        sync2 <= sync1;
    end

    for (genvar i = 0; i < 5; i++) begin : g_db
        logic        q;
        logic [31:0] cnt;

        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                q   <= 1'b0;
                cnt <= '0;
            end else if (sync2[i] == q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                q   <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end

        assign deb[i] = q;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) drop_d <= 1'b0;
        else       drop_d <= deb[4];
    end

    assign drop_pulse = deb[4] & ~drop_d;

    assign b_left  = deb[0];
    assign b_right = deb[1];
    assign b_up    = deb[2];
    assign b_down  = deb[3];
    assign lim_x   = sync2[5];
    assign lim_y   = sync2[6];
    assign lim_z   = sync2[7];

    assign dwell_to = (dwell == TO_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) cur <= S_HOME;
        else       cur <= nxt;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset || nxt != cur)  dwell <= '0;
        else if (dwell != '1)     dwell <= dwell + 32'd1;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset)
            ptimer <= '0;
        else if (cur == S_IDLE && nxt == S_PLAY)
            ptimer <= PLAY_LOAD;
        else if (cur == S_PLAY && ptimer != '0)
            ptimer <= ptimer - 32'd1;
    end

    // Position is an estimate from commanded motion, re-zeroed at home.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || lim_x)           xpos <= '0;
        else if (xf && xpos != X_MAX) xpos <= xpos + 32'd1;
        else if (xb && xpos != '0)    xpos <= xpos - 32'd1;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset || lim_y)           ypos <= '0;
        else if (yf && ypos != Y_MAX) ypos <= ypos + 32'd1;
        else if (yb && ypos != '0)    ypos <= ypos - 32'd1;
    end

    always_comb begin
        nxt = cur;
        xf  = 1'b0;
        xb  = 1'b0;
        yf  = 1'b0;
        yb  = 1'b0;
        zd  = 1'b0;
        zu  = 1'b0;
        gc  = 1'b0;
        flt = 1'b0;
        unique case (cur)
            S_HOME: begin
                zu = ~lim_z;
                xb = lim_z & ~lim_x;
                yb = lim_z & ~lim_y;
                if (lim_x && lim_y && lim_z) nxt = S_IDLE;
                else if (dwell_to)           nxt = S_FAULT;
            end
            S_IDLE: begin
                if (drop_pulse) nxt = S_PLAY;
            end
            S_PLAY: begin
                xf = b_right & ~b_left & (xpos != X_MAX);
                xb = b_left & ~b_right & ~lim_x;
                yf = b_up & ~b_down & (ypos != Y_MAX);
                yb = b_down & ~b_up & ~lim_y;
                if (drop_pulse || ptimer == '0) nxt = S_DROP;
            end
            S_DROP: begin
                zd = 1'b1;
                if (dwell == DROP_LAST) nxt = S_GRIP;
            end
            S_GRIP: begin
                gc = 1'b1;
                if (dwell == GRIP_LAST) nxt = S_RAISE;
            end
            S_RAISE: begin
                zu = ~lim_z;
                gc = 1'b1;
                if (lim_z)         nxt = S_RETURN;
                else if (dwell_to) nxt = S_FAULT;
            end
            S_RETURN: begin
                gc = 1'b1;
                xb = ~lim_x;
                yb = ~lim_y;
                if (lim_x && lim_y) nxt = S_RELEASE;
                else if (dwell_to)  nxt = S_FAULT;
            end
            S_RELEASE: begin
                if (dwell == GRIP_LAST) nxt = S_IDLE;
            end
            default: begin
                flt = 1'b1;
                nxt = S_FAULT;
            end
        endcase
    end

    assign x_fwd      = xf & ~reset;
    assign x_back     = xb & ~reset;
    assign y_fwd      = yf & ~reset;
    assign y_back     = yb & ~reset;
    assign z_down     = zd & ~reset;
    assign z_up       = zu & ~reset;
    assign grip_close = gc & ~reset;
    assign fault      = flt & ~reset;
    assign state      = reset ? 4'd0 : cur;

endmodule
